// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Contents:
//   fetch_entry_t     {pc, inst} pair buffered between fetch and decode
//   RESET_PC_DEFAULT  default PC after reset
//   DEPTH_DEFAULT     default buffer depth
//   ptr_w()           pointer width for a power-of-two depth
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 4;

    // Pointer width for a FIFO of 'depth' entries; depth is a power of two >= 2.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO used for the fetch buffer and the in-flight PC queue.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, wdata enqueue wdata (accepted when not full, or full with a pop)
//   pop         dequeue the head (ignored when empty)
//   flush       drop all entries; has priority over push/pop
//   full, empty occupancy flags
//   count       number of stored entries, 0..DEPTH
//   head        oldest entry (stable until popped)
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [ptr_w(DEPTH):0]  count,
    output entry_t                 head
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt == CW'(0));
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> (!full || pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (pop && !flush) |-> !empty);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches over a
// req/gnt/rvalid handshake, buffers {pc, inst} pairs for decode, and squashes
// everything in flight on a redirect from execute.
// Optional feature macro: FETCH_MISALIGN_EN (adds fetch_misalign; a misaligned
// redirect halts issue until the next aligned redirect).
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   imem_req, imem_addr            fetch request and word address
//   imem_gnt                       request accepted this cycle
//   imem_rvalid, imem_rdata        in-order response
//   redirect, redirect_pc          flush and restart fetch at redirect_pc
//   id_valid, id_ready             decode handshake on the buffer head
//   id_inst, id_pc                 head instruction and its PC
//   fetch_misalign                 (FETCH_MISALIGN_EN only) misaligned target seen
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] inst_count;
    logic          inst_full;
    logic          inst_empty;
    logic          rq_full;
    logic          rq_empty;
    logic [31:0]   rq_head;
    fetch_entry_t  inst_head;
    fetch_entry_t  resp_entry;

    logic          issue;
    logic          resp_drop;
    logic          resp_push;
    logic          deq;
    logic          halt;
    logic [31:0]   target_pc;
    logic [1:0]    unused_target_lsb;

    // Targets are always word-aligned; the low bits only matter for the misalign flag.
    assign target_pc         = {redirect_pc[31:2], 2'b00};
    assign unused_target_lsb = redirect_pc[1:0];

`ifdef FETCH_MISALIGN_EN
    logic misalign;

    // Sticky until the next redirect; a misaligned target stops all issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= |redirect_pc[1:0];
        end
    end

    assign fetch_misalign = misalign;
    assign halt           = misalign;
`else
    assign halt = 1'b0;
`endif

    // Issue only while the buffer can absorb every response already promised.
    always_comb begin
        imem_req = 1'b0;
        if (rst && !redirect && !halt &&
            (SW'(inst_count) + SW'(outstanding) < SW'(DEPTH))) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr  = pc;
    assign issue      = imem_req && imem_gnt;

    // A response is stale while drop_cnt is non-zero, or when it collides with a redirect.
    assign resp_drop  = imem_rvalid && (drop_cnt != CW'(0));
    assign resp_push  = imem_rvalid && !resp_drop && !redirect;
    assign deq        = id_valid && id_ready && !redirect;
    assign resp_entry = '{pc: rq_head, inst: imem_rdata};

    // Fetch address register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target_pc;
        end else if (issue) begin
            pc <= pc + 32'd4;
        end
    end

    // Every request still in flight at a redirect belongs to the old path,
    // including ones already marked for discard, so the new count is simply
    // what remains outstanding after this cycle's response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (redirect) begin
            drop_cnt <= outstanding - CW'(imem_rvalid);
        end else if (resp_drop) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // PCs of granted requests; its occupancy is the outstanding-request count.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (logic [31:0])
    ) u_req_pc_q (
        .clk   (clk),
        .rst_n (rst),
        .push  (issue),
        .wdata (pc),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .full  (rq_full),
        .empty (rq_empty),
        .count (outstanding),
        .head  (rq_head)
    );

    // Fetched {pc, inst} pairs waiting for decode.
    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_inst_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (resp_push),
        .wdata (resp_entry),
        .pop   (deq),
        .flush (redirect),
        .full  (inst_full),
        .empty (inst_empty),
        .count (inst_count),
        .head  (inst_head)
    );

    assign id_valid = !inst_empty;
    assign id_pc    = inst_head.pc;
    assign id_inst  = inst_head.inst;

    a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        resp_push |-> (!inst_full || deq));

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> !rq_empty);

    a_issue_has_room: assert property (@(posedge clk) disable iff (!rst)
        issue |-> !rq_full);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a memory model answers fetches in order,
// directed phases push expected PCs, and a monitor compares every decode handshake.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
`endif

    bit gnt_en, rv_en, gnt_rand, rv_rand, ready_en, ready_rand, ready_force;

    logic [31:0] exp_q[$];
    logic [31:0] mq[$];
    logic [31:0] next_exp;
    logic [31:0] mon_e;
    logic [31:0] hold_pc, hold_inst;
    logic        prev_hold = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          pops = 0;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
`ifdef FETCH_MISALIGN_EN
        .fetch_misalign (fetch_misalign),
`endif
        .id_pc       (id_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    task automatic check(input logic ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(next_exp);
            next_exp += 32'd4;
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Waits until all expected outputs were consumed; returns elapsed cycles.
    task automatic wait_drain(input int budget, input string name, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while (exp_q.size() != 0 && cyc < budget);
        check(exp_q.size() == 0, name, 32'(exp_q.size()), 32'h0);
        #1;
    endtask

    // Asserts reset for two cycles and checks the reset-state outputs.
    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        gnt_en = 0; rv_en = 0; gnt_rand = 0; rv_rand = 0;
        ready_en = 0; ready_rand = 0; ready_force = 0;
        exp_q.delete();
        step();
        @(negedge clk);
        check(imem_req == 1'b0, "rst_imem_req", 32'(imem_req), 32'h0);
        check(id_valid == 1'b0, "rst_id_valid", 32'(id_valid), 32'h0);
        check(id_pc == 32'h0,   "rst_id_pc",    id_pc,         32'h0);
        check(id_inst == 32'h0, "rst_id_inst",  id_inst,       32'h0);
        step();
    endtask

    // Memory model: drives grant/response a little after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                mq.delete();
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
                id_ready    = 1'b0;
            end else begin
                imem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
                if (mq.size() != 0 && (rv_rand ? ($urandom_range(0, 1) == 1) : rv_en)) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst_of(mq[0]);
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = 32'h0;
                end
                id_ready = ready_force ||
                           (ready_en && exp_q.size() != 0 &&
                            (ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1));
            end
        end
    end

    // Memory model: records grants and consumed responses at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (imem_rvalid) void'(mq.pop_front());
                if (imem_req && imem_gnt) mq.push_back(imem_addr);
            end
        end
    end

    // Monitor: checks every decode handshake and head stability under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check(id_valid && id_pc == hold_pc && id_inst == hold_inst,
                          "hold_stable", id_pc, hold_pc);
                end
                if (id_valid && id_ready && !redirect) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_output", id_pc, 32'h0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check(id_pc == mon_e && id_inst == inst_of(mon_e),
                              "id_pc_inst", id_pc, mon_e);
                    end
                end
                prev_hold = id_valid && !id_ready && !redirect;
                hold_pc   = id_pc;
                hold_inst = id_inst;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int pops_start;
        #2 rst = 1'b0;

        // Zero-wait memory, decode always ready: one output per cycle from cycle 3.
        do_reset();
        push_seq(32'h0, 8);
        gnt_en = 1; rv_en = 1; ready_en = 1; rst = 1'b1;
        wait_drain(40, "p1_drain", cyc);
        check(cyc == 10, "p1_throughput", 32'(cyc), 32'd10);

        // Decode stalled: buffer fills to DEPTH and issue stops at 0x10.
        do_reset();
        push_seq(32'h0, 6);
        gnt_en = 1; rv_en = 1; ready_en = 0; rst = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check(imem_req == 1'b0, "p2_req_stopped", 32'(imem_req), 32'h0);
        check(imem_addr == 32'h10, "p2_next_addr", imem_addr, 32'h10);
        check(id_valid && id_pc == 32'h0, "p2_head", id_pc, 32'h0);
        step();
        ready_en = 1;
        wait_drain(40, "p2_drain", cyc);

        // Redirect with two requests outstanding: both responses discarded.
        do_reset();
        gnt_en = 1; rv_en = 0; ready_en = 1; rst = 1'b1;
        step();
        step();
        gnt_en = 0; redirect = 1'b1; redirect_pc = 32'h100;
        push_seq(32'h100, 4);
        @(negedge clk);
        check(imem_req == 1'b0, "p3_no_req_on_redirect", 32'(imem_req), 32'h0);
        step();
        redirect = 1'b0; gnt_en = 1; rv_en = 1;
        wait_drain(40, "p3_drain", cyc);

        // Redirect colliding with a response and a decode pop.
        do_reset();
        gnt_en = 1; rv_en = 0; rst = 1'b1;
        step();
        step();
        rv_en = 1;
        step();
        redirect = 1'b1; redirect_pc = 32'h200; ready_force = 1;
        push_seq(32'h200, 3);
        @(negedge clk);
        check(id_valid && id_pc == 32'h0, "p4_head_before_flush", id_pc, 32'h0);
        step();
        redirect = 1'b0; ready_force = 0; ready_en = 1;
        @(negedge clk);
        check(id_valid == 1'b0, "p4_empty_after_flush", 32'(id_valid), 32'h0);
        step();
        wait_drain(40, "p4_drain", cyc);

        // Random grant/response/ready backpressure with periodic redirects.
        do_reset();
        next_exp = 32'h0;
        top_up();
        gnt_rand = 1; rv_rand = 1; ready_en = 1; ready_rand = 1; rst = 1'b1;
        pops_start = pops;
        for (int c = 0; c < 3000; c++) begin
            step();
            redirect = 1'b0;
            if (c % 700 == 699) begin
                redirect    = 1'b1;
                redirect_pc = 32'(32'h1000 * (c / 700 + 1) + 32'h40);
                exp_q.delete();
                next_exp    = redirect_pc;
            end
            top_up();
        end
        redirect = 1'b0; ready_en = 0;
        check(pops - pops_start > 300, "p5_progress", 32'(pops - pops_start), 32'd300);

`ifdef FETCH_MISALIGN_EN
        // Misaligned redirect halts issue until an aligned one.
        do_reset();
        gnt_en = 1; rv_en = 1; rst = 1'b1;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check(fetch_misalign == 1'b1, "ma_flag_set", 32'(fetch_misalign), 32'h1);
        check(imem_req == 1'b0, "ma_no_req", 32'(imem_req), 32'h0);
        repeat (3) step();
        @(negedge clk);
        check(imem_req == 1'b0, "ma_still_halted", 32'(imem_req), 32'h0);
        step();
        redirect = 1'b1; redirect_pc = 32'h200; ready_en = 1;
        push_seq(32'h200, 4);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check(fetch_misalign == 1'b0, "ma_flag_clear", 32'(fetch_misalign), 32'h0);
        check(imem_req && imem_addr == 32'h200, "ma_resume", imem_addr, 32'h200);
        step();
        wait_drain(40, "ma_drain", cyc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
